nibble_serial_adder_ctrl: RTL
=============================

Name: nibble_serial_adder_ctrl

Overview:
- Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit ripple adder, one nibble per clock, LSB nibble first.
- Sits between the CPU control unit (requester) and the register-file write path (result consumer).
- Uses valid/ready handshakes on both sides.
- Produces sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBS, WIDTH/4, derived localparam: number of adder passes.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- req_valid  input  1  request operands valid
- req_ready  output  1  block can accept request
- req_a  input  WIDTH  operand A
- req_b  input  WIDTH  operand B
- req_sub  input  1  0 = A+B, 1 = A-B
- flush  input  1  synchronous abort, returns to IDLE
- res_valid  output  1  result valid
- res_ready  input  1  consumer accepts result
- res_sum  output  WIDTH  result
- res_cout  output  1  final carry-out (sub: 1 = no borrow)
- res_ovf  output  1  signed overflow
- res_zero  output  1  res_sum == 0
- busy  output  1  state != IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on resetn.
- Reset values: state = IDLE, req_ready = 1, res_valid = 0, busy = 0, res_sum = 0, res_cout = 0, res_ovf = 0, res_zero = 0, nibble counter = 0, carry register = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at edge k: capture a_q = req_a, b_q = req_b XOR {WIDTH{req_sub}}, op_q = req_sub.
  - At the same edge: carry = req_sub, cnt = 0, clear res_sum, go to RUN.
- RUN:
  - req_ready = 0.
  - Each cycle the shared adder computes a_q[4*cnt+:4] + b_q[4*cnt+:4] + carry.
  - The sum nibble is written to res_sum[4*cnt+:4], carry <= adder cout, cnt <= cnt + 1.
  - When cnt == NIBS-1 the edge also writes the flags and moves to DONE.
  - res_cout = adder cout.
  - res_ovf = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]), where b_q is the inverted operand for subtract.
  - res_zero = full result == 0, including the nibble written on that edge.
- Latency: res_valid asserts after edge k+NIBS (4 cycles for WIDTH = 16). Throughput is one operation per NIBS+2 cycles minimum.
- DONE:
  - res_valid = 1; res_sum and all flags are held stable while res_ready = 0.
  - On res_ready: go to IDLE, res_valid = 0.
  - Outputs keep their last values until the next request is accepted.
  - req_ready stays 0 in DONE. No same-cycle handoff; a new request is accepted the cycle after DONE exits.
- flush: in any state, forces IDLE, clears res_valid and cnt, and discards the in-flight result. flush has priority over res_ready and over a new request in the same cycle.
- Reset mid-operation: asynchronously returns to the reset values above. No partial result is ever presented.
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - Subtract is a + ~b + 1, implemented with initial carry = 1.
  - The counter width is $clog2(NIBS); it never wraps past NIBS-1 because the state exits at the final nibble.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE/RUN/DONE), NIB_W = 4.
- Sub-module nibble_add4: combinational 4-bit ripple adder (a[3:0], b[3:0], cin, cout, s[3:0]) built from 1-bit full adders. It is instantiated exactly once and is the only adder in the block.
- The controller holds the FSM, counter, operand registers, nibble muxing and flag logic.

Test Plan:
- Add: 0x1234 + 0x0FCD -> res_sum = 0x2201, cout 0, ovf 0, zero 0; res_valid rises exactly 4 cycles after the handshake edge.
- Wrap: 0xFFFF + 0x0001 -> 0x0000, cout 1, zero 1, ovf 0.
- Signed overflow: 0x7FFF + 0x0001 -> 0x8000, ovf 1, cout 0. Sub 0x8000 - 0x0001 -> 0x7FFF, ovf 1, cout 1.
- Borrow: sub 0x0005 - 0x0007 -> 0xFFFE, cout 0, ovf 0, zero 0. Sub 0x1234 - 0x1234 -> 0x0000, zero 1, cout 1.
- Backpressure: hold res_ready = 0 for 3 cycles in DONE -> outputs stable, req_ready = 0, req_valid ignored. Release -> IDLE next cycle, then a new request is accepted.
- Abort/reset: assert flush during RUN nibble 2 -> IDLE next edge, res_valid never asserts. Drop resetn asynchronously mid-RUN -> all outputs at reset values immediately. A following 0x0001 + 0x0002 returns 0x0003.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4.sv
// Combinational 4-bit ripple-carry adder: one full adder per bit, carry chained LSB to MSB.
module nibble_add4
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer that reuses a single 4-bit adder, one nibble per clock,
// with valid/ready handshakes toward the requester and the result consumer.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_sub,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_zero,
    output logic             busy
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;

    logic [NIB_W-1:0]   nib_a, nib_b, nib_s;
    logic               nib_cout;
    logic               last_nib;

    assign nib_a    = a_q[int'(cnt_q)*NIB_W +: NIB_W];
    assign nib_b    = b_q[int'(cnt_q)*NIB_W +: NIB_W];
    assign last_nib = (cnt_q == CNT_W'(NIBS - 1));

    nibble_add4 u_add4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        a_d     = a_q;
        b_d     = b_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Subtract is a + ~b + 1: invert B here and seed the carry with 1.
                        a_d     = req_a;
                        b_d     = req_b ^ {WIDTH{req_sub}};
                        carry_d = req_sub;
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_d[int'(cnt_q)*NIB_W +: NIB_W] = nib_s;
                    carry_d = nib_cout;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_nib) begin
                        cout_d  = nib_cout;
                        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[NIB_W-1] != a_q[WIDTH-1]);
                        zero_d  = (sum_d == '0);
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Operand registers are only read in RUN after a capture, so they need no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign req_ready = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;
    assign res_zero  = zero_q;

endmodule
